btb_table: RTL and testbench
============================

Name: btb_table

Overview:
- Fully associative 8-line branch target buffer.
- Looks up the fetch PC combinationally and supplies a predicted next PC to IF.
- Accepts resolved-branch updates from EX; writes into matched, free, or victim lines.
- Drives the hit/hit_line/en side of the LRU replacement unit and consumes its lru_line victim output. It is the consumer end of the LRU interface.

Parameters:
- DATA_WIDTH, 32, PC/target width; tag = PC[DATA_WIDTH-1:2], DATA_WIDTH-2 bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  global enable; when 0, no state changes and lru_en=0.
- pc  input  DATA_WIDTH  fetch PC to look up.
- hit  output  1  lookup hit (valid line whose tag equals pc[DATA_WIDTH-1:2]).
- hit_line  output  `BTB_LINE_SIZE  matching line index; 0 on miss.
- pred_taken  output  1  hit & counter[1] of hit line.
- next_pc  output  DATA_WIDTH  pred_taken ? stored target : pc+4.
- upd_en  input  1  EX reports a resolved branch this cycle.
- upd_pc  input  DATA_WIDTH  PC of resolved branch.
- upd_taken  input  1  branch outcome.
- upd_target  input  DATA_WIDTH  resolved target.
- lru_line  input  `BTB_LINE_SIZE  victim line from LRU unit.
- lru_en  output  1  en & upd_en & (upd_match | upd_taken).
- lru_hit  output  1  write went to a matched line or a free (invalid) line.
- lru_hit_line  output  `BTB_LINE_SIZE  line written this cycle; 0 when lru_hit=0.

Behaviour:
- State per line: valid (1b), tag (DATA_WIDTH-2), target (DATA_WIDTH), 2-bit saturating counter.
  - 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Reset (async, immediate): all valid=0, counters=01, tags/targets=0.
  - Outputs during reset: hit=0, hit_line=0, pred_taken=0, next_pc=pc+4, lru_en=0, lru_hit=0, lru_hit_line=0.
- Lookup: purely combinational from current state, zero latency.
  - next_pc = pc+4 modulo 2^DATA_WIDTH (wraps).
- Update: processed on the clock edge when en & upd_en. upd_match = valid line with tag == upd_pc[DATA_WIDTH-1:2].
  - Match, taken: counter saturating +1 (11 stays 11); target <= upd_target.
  - Match, not taken: counter saturating -1 (00 stays 00); target unchanged; line stays valid.
  - No match, taken: allocate. Destination is the lowest-index invalid line if any exist (lru_hit=1, lru_hit_line=that index); otherwise lru_line (lru_hit=0). Written with valid=1, tag, target=upd_target, counter=10.
  - No match, not taken: no allocation, no state change, lru_en=0.
- Multiple matches cannot occur, because allocation happens only on no-match. The match encoder still resolves to the lowest index.
- Simultaneous lookup and update of the same PC: lookup reflects pre-edge state; new contents are visible the cycle after the edge.
- en=0: updates ignored; lookup outputs remain valid.
- Reset asserted mid-update: update discarded; state cleared asynchronously.
- lru_en/lru_hit/lru_hit_line are combinational from update inputs and current state, in the same cycle as the write.

Decomposition:
- defines.vh: BTB_LINE_NUM (8), BTB_LINE_SIZE (3), counter encodings (SNT/WNT/WT/ST), allocation init value (WT).
- One sub-module, btb_tag_match: 8-way tag compare plus lowest-index encoder, outputs match flag and index. Instantiated twice, for lookup and update ports.

Test Plan:
- Reset, then pc=0x00001000 -> hit=0, pred_taken=0, next_pc=0x00001004; lru_en=0.
- Update upd_pc=0x1000, taken, target=0x2000 -> lru_en=1, lru_hit=1, lru_hit_line=0. Next cycle pc=0x1000 -> hit=1, hit_line=0, pred_taken=1 (counter 10), next_pc=0x2000.
- Same entry, two not-taken updates -> counter 10→01→00; pc=0x1000 gives hit=1, pred_taken=0, next_pc=0x1004. A third not-taken update keeps 00.
- Fill lines 0..7 with taken updates (PCs 0x1000..0x101C), then update new PC 0x3000 taken with lru_line=5 -> lru_hit=0, line 5 overwritten. Lookup 0x1014 misses; lookup 0x3000 hits with hit_line=5.
- Update not-taken for unknown PC 0x4000 -> lru_en=0, no line changes (all prior lookups unchanged).
- Assert rst for half a cycle after entries exist -> hit drops to 0 immediately (asynchronous). Update presented in the same cycle has no effect after reset release.
- Wrap check: pc=0xFFFFFFFC on miss -> next_pc=0x00000000.

Source files
------------

// File: rtl/btb_table_pkg.sv
// Shared definitions for the branch target buffer.
// Provides the line count and index width, the 2-bit counter encodings, the
// counter value used on allocation, and saturating counter helpers.
package btb_table_pkg;

  localparam int unsigned BTB_LINE_NUM  = 8;
  localparam int unsigned BTB_LINE_SIZE = 3;

  typedef enum logic [1:0] {
    CntSnt = 2'b00,
    CntWnt = 2'b01,
    CntWt  = 2'b10,
    CntSt  = 2'b11
  } cnt_e;

  localparam cnt_e CntAllocInit = CntWt;

  function automatic logic [1:0] cnt_sat_inc(input logic [1:0] cnt);
    return (cnt == CntSt) ? cnt : cnt + 2'd1;
  endfunction

  function automatic logic [1:0] cnt_sat_dec(input logic [1:0] cnt);
    return (cnt == CntSnt) ? cnt : cnt - 2'd1;
  endfunction

endpackage

// File: rtl/btb_table_if.sv
// Signal bundle between the BTB and its neighbours (IF lookup, EX update, LRU).
// master: the side driving pc/update/lru_line (fetch, execute, LRU unit).
// slave:  the BTB itself.
interface btb_table_if
  import btb_table_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) ();

  // Fetch-side lookup
  logic                     en;
  logic [DATA_WIDTH-1:0]    pc;
  logic                     hit;
  logic [BTB_LINE_SIZE-1:0] hit_line;
  logic                     pred_taken;
  logic [DATA_WIDTH-1:0]    next_pc;
  // Resolved-branch update
  logic                     upd_en;
  logic [DATA_WIDTH-1:0]    upd_pc;
  logic                     upd_taken;
  logic [DATA_WIDTH-1:0]    upd_target;
  // LRU replacement unit
  logic [BTB_LINE_SIZE-1:0] lru_line;
  logic                     lru_en;
  logic                     lru_hit;
  logic [BTB_LINE_SIZE-1:0] lru_hit_line;

  modport master (
    output en, pc, upd_en, upd_pc, upd_taken, upd_target, lru_line,
    input  hit, hit_line, pred_taken, next_pc, lru_en, lru_hit, lru_hit_line
  );

  modport slave (
    input  en, pc, upd_en, upd_pc, upd_taken, upd_target, lru_line,
    output hit, hit_line, pred_taken, next_pc, lru_en, lru_hit, lru_hit_line
  );

endinterface

// File: rtl/btb_tag_match.sv
// 8-way tag comparator with lowest-index priority encoder.
// Ports:
//   valid_i  per-line valid bits
//   tags_i   per-line stored tags
//   tag_i    tag being searched for
//   match_o  some valid line holds tag_i
//   idx_o    lowest matching line index (0 when no match)
module btb_tag_match
  import btb_table_pkg::*;
#(
  parameter int unsigned TagWidth = 30
) (
  input  logic [BTB_LINE_NUM-1:0]               valid_i,
  input  logic [BTB_LINE_NUM-1:0][TagWidth-1:0] tags_i,
  input  logic [TagWidth-1:0]                   tag_i,
  output logic                                  match_o,
  output logic [BTB_LINE_SIZE-1:0]              idx_o
);

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    match_o = 1'b0;
    idx_o   = '0;
    for (int i = BTB_LINE_NUM - 1; i >= 0; i--) begin
      if (valid_i[i] && (tags_i[i] == tag_i)) begin
        match_o = 1'b1;
        idx_o   = BTB_LINE_SIZE'(i);
      end
    end
  end

endmodule

// File: rtl/btb_table.sv
// Fully associative 8-line branch target buffer.
// Looks up the fetch PC combinationally and predicts the next PC; absorbs
// resolved-branch updates into a matched, free, or LRU-victim line.
// Ports:
//   clk  clock, state updates on rising edge
//   rst  asynchronous active-high reset
//   bus  btb_table_if slave: lookup (en, pc -> hit, hit_line, pred_taken,
//        next_pc), update (upd_*), LRU (lru_line -> lru_en, lru_hit,
//        lru_hit_line)
module btb_table
  import btb_table_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic        clk,
  input logic        rst,
  btb_table_if.slave bus
);

  localparam int unsigned TagW = DATA_WIDTH - 2;

  logic [BTB_LINE_NUM-1:0]                 valid_q, valid_d;
  logic [BTB_LINE_NUM-1:0][TagW-1:0]       tag_q, tag_d;
  logic [BTB_LINE_NUM-1:0][DATA_WIDTH-1:0] target_q, target_d;
  logic [BTB_LINE_NUM-1:0][1:0]            cnt_q, cnt_d;

  logic                     look_match;
  logic [BTB_LINE_SIZE-1:0] look_idx;
  logic                     upd_match;
  logic [BTB_LINE_SIZE-1:0] upd_idx;
  logic                     free_found;
  logic [BTB_LINE_SIZE-1:0] free_idx;
  logic [BTB_LINE_SIZE-1:0] alloc_idx;
  logic                     lru_en;
  logic                     lru_hit;
  logic [BTB_LINE_SIZE-1:0] lru_hit_line;
  logic                     pred_taken;

  btb_tag_match #(
    .TagWidth(TagW)
  ) u_look_match (
    .valid_i(valid_q),
    .tags_i (tag_q),
    .tag_i  (bus.pc[DATA_WIDTH-1:2]),
    .match_o(look_match),
    .idx_o  (look_idx)
  );

  btb_tag_match #(
    .TagWidth(TagW)
  ) u_upd_match (
    .valid_i(valid_q),
    .tags_i (tag_q),
    .tag_i  (bus.upd_pc[DATA_WIDTH-1:2]),
    .match_o(upd_match),
    .idx_o  (upd_idx)
  );

  // Lowest-index invalid line, used before falling back to the LRU victim.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = BTB_LINE_NUM - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = BTB_LINE_SIZE'(i);
      end
    end
  end

  // Lookup path
  assign pred_taken     = look_match & cnt_q[look_idx][1];
  assign bus.hit        = look_match;
  assign bus.hit_line   = look_idx;
  assign bus.pred_taken = pred_taken;
  assign bus.next_pc    = pred_taken ? target_q[look_idx] : bus.pc + DATA_WIDTH'(4);

  // Update path; rst gating keeps the LRU side quiet while reset is held.
  always_comb begin
    valid_d      = valid_q;
    tag_d        = tag_q;
    target_d     = target_q;
    cnt_d        = cnt_q;
    lru_en       = 1'b0;
    lru_hit      = 1'b0;
    lru_hit_line = '0;
    alloc_idx    = free_found ? free_idx : bus.lru_line;
    if (!rst && bus.en && bus.upd_en) begin
      if (upd_match) begin
        lru_en       = 1'b1;
        lru_hit      = 1'b1;
        lru_hit_line = upd_idx;
        if (bus.upd_taken) begin
          cnt_d[upd_idx]    = cnt_sat_inc(cnt_q[upd_idx]);
          target_d[upd_idx] = bus.upd_target;
        end else begin
          cnt_d[upd_idx] = cnt_sat_dec(cnt_q[upd_idx]);
        end
      end else if (bus.upd_taken) begin
        lru_en = 1'b1;
        if (free_found) begin
          lru_hit      = 1'b1;
          lru_hit_line = free_idx;
        end
        valid_d[alloc_idx]  = 1'b1;
        tag_d[alloc_idx]    = bus.upd_pc[DATA_WIDTH-1:2];
        target_d[alloc_idx] = bus.upd_target;
        cnt_d[alloc_idx]    = CntAllocInit;
      end
    end
  end

  assign bus.lru_en       = lru_en;
  assign bus.lru_hit      = lru_hit;
  assign bus.lru_hit_line = lru_hit_line;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= '0;
      tag_q    <= '0;
      target_q <= '0;
      for (int i = 0; i < BTB_LINE_NUM; i++) begin
        cnt_q[i] <= CntWnt;
      end
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_btb_table.sv
// Directed self-checking bench for btb_table.
module tb_btb_table;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  btb_table_if #(.DATA_WIDTH(32)) bus ();

  btb_table #(
    .DATA_WIDTH(32)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc, input logic exp_hit,
                        input logic [2:0] exp_line, input logic exp_pred,
                        input logic [31:0] exp_next);
    bus.pc = pc;
    #1;
    check_eq({tag, ".hit"}, 32'(bus.hit), 32'(exp_hit));
    check_eq({tag, ".hit_line"}, 32'(bus.hit_line), 32'(exp_line));
    check_eq({tag, ".pred_taken"}, 32'(bus.pred_taken), 32'(exp_pred));
    check_eq({tag, ".next_pc"}, bus.next_pc, exp_next);
  endtask

  // Present one update, check the LRU side before the edge, then commit it.
  task automatic update(input string tag, input logic [31:0] upc, input logic taken,
                        input logic [31:0] tgt, input logic [2:0] victim,
                        input logic exp_en, input logic exp_hit, input logic [2:0] exp_line);
    bus.upd_en     = 1'b1;
    bus.upd_pc     = upc;
    bus.upd_taken  = taken;
    bus.upd_target = tgt;
    bus.lru_line   = victim;
    #1;
    check_eq({tag, ".lru_en"}, 32'(bus.lru_en), 32'(exp_en));
    check_eq({tag, ".lru_hit"}, 32'(bus.lru_hit), 32'(exp_hit));
    check_eq({tag, ".lru_hit_line"}, 32'(bus.lru_hit_line), 32'(exp_line));
    @(posedge clk);
    #1;
    bus.upd_en = 1'b0;
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    rst            = 1'b1;
    bus.en         = 1'b1;
    bus.pc         = 32'h0000_1000;
    bus.upd_en     = 1'b1;
    bus.upd_pc     = 32'h0000_1000;
    bus.upd_taken  = 1'b1;
    bus.upd_target = 32'h0000_2000;
    bus.lru_line   = 3'd0;

    // Reset state: lookup misses and LRU side silent despite a pending update
    #2;
    lookup("rst", 32'h0000_1000, 1'b0, 3'd0, 1'b0, 32'h0000_1004);
    check_eq("rst.lru_en", 32'(bus.lru_en), 32'd0);
    check_eq("rst.lru_hit", 32'(bus.lru_hit), 32'd0);
    bus.upd_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    lookup("miss0", 32'h0000_1000, 1'b0, 3'd0, 1'b0, 32'h0000_1004);
    check_eq("idle.lru_en", 32'(bus.lru_en), 32'd0);

    // First allocation goes to free line 0; same-cycle lookup sees old state
    bus.pc = 32'h0000_1000;
    update("alloc0", 32'h0000_1000, 1'b1, 32'h0000_2000, 3'd4, 1'b1, 1'b1, 3'd0);
    lookup("hit0", 32'h0000_1000, 1'b1, 3'd0, 1'b1, 32'h0000_2000);

    // Counter 10 -> 01 -> 00 -> 00
    update("nt1", 32'h0000_1000, 1'b0, 32'h0, 3'd0, 1'b1, 1'b1, 3'd0);
    lookup("wnt", 32'h0000_1000, 1'b1, 3'd0, 1'b0, 32'h0000_1004);
    update("nt2", 32'h0000_1000, 1'b0, 32'h0, 3'd0, 1'b1, 1'b1, 3'd0);
    update("nt3", 32'h0000_1000, 1'b0, 32'h0, 3'd0, 1'b1, 1'b1, 3'd0);
    lookup("snt", 32'h0000_1000, 1'b1, 3'd0, 1'b0, 32'h0000_1004);
    // One taken from 00 reaches 01 only (still not taken), second reaches 10
    update("t1", 32'h0000_1000, 1'b1, 32'h0000_2222, 3'd0, 1'b1, 1'b1, 3'd0);
    lookup("after_t1", 32'h0000_1000, 1'b1, 3'd0, 1'b0, 32'h0000_1004);
    update("t2", 32'h0000_1000, 1'b1, 32'h0000_2000, 3'd0, 1'b1, 1'b1, 3'd0);
    lookup("after_t2", 32'h0000_1000, 1'b1, 3'd0, 1'b1, 32'h0000_2000);

    // Fill lines 1..7
    for (int i = 1; i < 8; i++) begin
      update($sformatf("fill%0d", i), 32'h0000_1000 + 32'(4 * i), 1'b1,
             32'h0000_5000 + 32'(16 * i), 3'd0, 1'b1, 1'b1, 3'(i));
    end
    lookup("fill7", 32'h0000_101C, 1'b1, 3'd7, 1'b1, 32'h0000_5070);

    // Full table: victim comes from the LRU unit
    update("victim", 32'h0000_3000, 1'b1, 32'h0000_7000, 3'd5, 1'b1, 1'b0, 3'd0);
    lookup("evicted", 32'h0000_1014, 1'b0, 3'd0, 1'b0, 32'h0000_1018);
    lookup("new5", 32'h0000_3000, 1'b1, 3'd5, 1'b1, 32'h0000_7000);

    // Not-taken miss: nothing allocated
    update("nt_miss", 32'h0000_4000, 1'b0, 32'h0000_9000, 3'd2, 1'b0, 1'b0, 3'd0);
    lookup("nt_miss_pc", 32'h0000_4000, 1'b0, 3'd0, 1'b0, 32'h0000_4004);
    lookup("keep5", 32'h0000_3000, 1'b1, 3'd5, 1'b1, 32'h0000_7000);
    lookup("keep2", 32'h0000_1008, 1'b1, 3'd2, 1'b1, 32'h0000_5020);

    // en=0: update ignored, lookup still works
    bus.en = 1'b0;
    update("dis", 32'h0000_8000, 1'b1, 32'h0000_8888, 3'd1, 1'b0, 1'b0, 3'd0);
    lookup("dis_look", 32'h0000_1000, 1'b1, 3'd0, 1'b1, 32'h0000_2000);
    bus.en = 1'b1;
    lookup("dis_miss", 32'h0000_8000, 1'b0, 3'd0, 1'b0, 32'h0000_8004);

    // Asynchronous reset for half a cycle with an update pending across the edge
    bus.pc         = 32'h0000_3000;
    bus.upd_en     = 1'b1;
    bus.upd_pc     = 32'h0000_6000;
    bus.upd_taken  = 1'b1;
    bus.upd_target = 32'h0000_6666;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("arst.hit", 32'(bus.hit), 32'd0);
    check_eq("arst.lru_en", 32'(bus.lru_en), 32'd0);
    @(posedge clk);
    #1;
    bus.upd_en = 1'b0;
    rst        = 1'b0;
    @(posedge clk);
    #1;
    lookup("post_rst_upd", 32'h0000_6000, 1'b0, 3'd0, 1'b0, 32'h0000_6004);
    lookup("post_rst_old", 32'h0000_3000, 1'b0, 3'd0, 1'b0, 32'h0000_3004);

    // Wrap of pc+4
    lookup("wrap", 32'hFFFF_FFFC, 1'b0, 3'd0, 1'b0, 32'h0000_0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
